// File: rtl/camac_dataway_initiator.sv
// CAMAC crate-controller dataway initiator: runs one N.A.F (or Z/C) dataway
// cycle per accepted command, samples R/Q/X during S1 and returns a response.
// Also synchronises the LAM lines.
module camac_dataway_initiator #(
  parameter int unsigned T_SETUP = 10,
  parameter int unsigned T_S1    = 5,
  parameter int unsigned T_GAP   = 5,
  parameter int unsigned T_S2    = 5,
  parameter int unsigned T_HOLD  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_n,
  input  logic [3:0]  cmd_a,
  input  logic [4:0]  cmd_f,
  input  logic [23:0] cmd_wdata,
  input  logic        cmd_z,
  input  logic        cmd_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_rdata,
  output logic        rsp_q,
  output logic        rsp_x,
  output logic [23:0] cw_n,
  output logic [3:0]  cw_a,
  output logic [4:0]  cw_f,
  output logic [23:0] cw_w,
  output logic        cw_b,
  output logic        cw_s1,
  output logic        cw_s2,
  output logic        cw_z,
  output logic        cw_c,
  input  logic [23:0] cw_r,
  input  logic        cw_q,
  input  logic        cw_x,
  input  logic [23:0] cw_l,
  output logic [23:0] lam,
  output logic        lam_any
);

  localparam int unsigned M1    = (T_SETUP > T_S1) ? T_SETUP : T_S1;
  localparam int unsigned M2    = (M1 > T_GAP) ? M1 : T_GAP;
  localparam int unsigned M3    = (M2 > T_S2) ? M2 : T_S2;
  localparam int unsigned P_MAX = (M3 > T_HOLD) ? M3 : T_HOLD;
  localparam int          CW    = (P_MAX < 2) ? 1 : $clog2(P_MAX);

  // A zero-length phase still lasts one clock.
  localparam logic [CW-1:0] L_SETUP = CW'((T_SETUP == 0) ? 0 : T_SETUP - 1);
  localparam logic [CW-1:0] L_S1    = CW'((T_S1 == 0) ? 0 : T_S1 - 1);
  localparam logic [CW-1:0] L_GAP   = CW'((T_GAP == 0) ? 0 : T_GAP - 1);
  localparam logic [CW-1:0] L_S2    = CW'((T_S2 == 0) ? 0 : T_S2 - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'((T_HOLD == 0) ? 0 : T_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_S1, ST_GAP, ST_S2, ST_HOLD, ST_RESP
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;

  logic [4:0]  r_n;
  logic [3:0]  r_a;
  logic [4:0]  r_f;
  logic [23:0] r_wdata;
  logic        r_z, r_c;

  logic [23:0] r_smp_r;
  logic        r_smp_q, r_smp_x;

  logic [23:0] r_rsp_rdata;
  logic        r_rsp_q, r_rsp_x, r_rsp_valid;

  logic [23:0] r_cw_n, r_cw_w;
  logic [3:0]  r_cw_a;
  logic [4:0]  r_cw_f;
  logic        r_cw_b, r_cw_s1, r_cw_s2, r_cw_z, r_cw_c;

  logic [23:0] r_lam_meta, r_lam;
  logic        r_lam_any;

  logic        w_accept, w_busy, w_addr, w_read, w_write, w_sample, w_to_resp;
  logic [23:0] w_onehot;
  logic [23:0] w_cw_n, w_cw_w;
  logic [3:0]  w_cw_a;
  logic [4:0]  w_cw_f;
  logic        w_cw_b, w_cw_s1, w_cw_s2, w_cw_z, w_cw_c, w_rsp_valid;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
  assign w_addr    = !r_z && !r_c;
  assign w_read    = (r_f[4:3] == 2'b00);
  assign w_write   = (r_f[4:3] == 2'b10);
  assign w_busy    = (r_state == ST_SETUP) || (r_state == ST_S1) || (r_state == ST_GAP) ||
                     (r_state == ST_S2) || (r_state == ST_HOLD);
  // Dataway lines are registered, so the strobe is still high at this edge
  // while the state has already left S1: this edge closes the last S1 clock.
  assign w_sample  = r_cw_s1 && !w_cw_s1;
  assign w_to_resp = (r_state == ST_HOLD) && (w_next == ST_RESP);

  function automatic logic [CW-1:0] f_load(input state_t s);
    case (s)
      ST_SETUP: f_load = L_SETUP;
      ST_S1:    f_load = L_S1;
      ST_GAP:   f_load = L_GAP;
      ST_S2:    f_load = L_S2;
      ST_HOLD:  f_load = L_HOLD;
      default:  f_load = '0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: phases advance when the shared down-counter expires.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid)                 w_next = ST_SETUP;
      ST_SETUP: if (r_cnt == '0)               w_next = ST_S1;
      ST_S1:    if (r_cnt == '0)               w_next = ST_GAP;
      ST_GAP:   if (r_cnt == '0)               w_next = ST_S2;
      ST_S2:    if (r_cnt == '0)               w_next = ST_HOLD;
      ST_HOLD:  if (r_cnt == '0)               w_next = ST_RESP;
      ST_RESP:  if (r_rsp_valid && rsp_ready)  w_next = ST_IDLE;
      default:                                 w_next = ST_IDLE;
    endcase
  end

  // Phase counter: reload on every phase change, otherwise count down.
  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= f_load(w_next);
    else if (r_cnt != '0)       r_cnt <= r_cnt - CW'(1);
  end

  // Command capture at acceptance only; Z takes priority over C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n <= '0; r_a <= '0; r_f <= '0; r_wdata <= '0; r_z <= 1'b0; r_c <= 1'b0;
    end else if (w_accept) begin
      r_n     <= cmd_n;
      r_a     <= cmd_a;
      r_f     <= cmd_f;
      r_wdata <= cmd_wdata;
      r_z     <= cmd_z;
      r_c     <= cmd_c & ~cmd_z;
    end
  end

  // Output decode: next values for the registered dataway lines and rsp_valid.
  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < 23; i++) w_onehot[i] = (r_n == 5'(i + 1));
    w_cw_n      = '0;
    w_cw_a      = '0;
    w_cw_f      = '0;
    w_cw_w      = '0;
    w_cw_b      = w_busy;
    w_cw_s1     = (r_state == ST_S1) && w_addr;
    w_cw_s2     = (r_state == ST_S2);
    w_cw_z      = w_busy && r_z;
    w_cw_c      = w_busy && r_c;
    w_rsp_valid = (r_state == ST_RESP) && !(r_rsp_valid && rsp_ready);
    if (w_busy && w_addr) begin
      w_cw_n = w_onehot;
      w_cw_a = r_a;
      w_cw_f = r_f;
      if (w_write) w_cw_w = r_wdata;
    end
  end

  // Registered dataway outputs and response-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cw_n <= '0; r_cw_a <= '0; r_cw_f <= '0; r_cw_w <= '0;
      r_cw_b <= 1'b0; r_cw_s1 <= 1'b0; r_cw_s2 <= 1'b0;
      r_cw_z <= 1'b0; r_cw_c <= 1'b0; r_rsp_valid <= 1'b0;
    end else begin
      r_cw_n <= w_cw_n; r_cw_a <= w_cw_a; r_cw_f <= w_cw_f; r_cw_w <= w_cw_w;
      r_cw_b <= w_cw_b; r_cw_s1 <= w_cw_s1; r_cw_s2 <= w_cw_s2;
      r_cw_z <= w_cw_z; r_cw_c <= w_cw_c; r_rsp_valid <= w_rsp_valid;
    end
  end

  // Capture R/Q/X on the final S1 clock; cleared at acceptance.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_smp_r <= '0; r_smp_q <= 1'b0; r_smp_x <= 1'b0;
    end else if (w_sample) begin
      r_smp_r <= cw_r; r_smp_q <= cw_q; r_smp_x <= cw_x;
    end
  end

  // Response fields latched once per cycle so they hold while rsp_valid=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata <= '0; r_rsp_q <= 1'b0; r_rsp_x <= 1'b0;
    end else if (w_to_resp) begin
      r_rsp_rdata <= (w_addr && w_read) ? r_smp_r : '0;
      r_rsp_q     <= w_addr && r_smp_q;
      r_rsp_x     <= w_addr && r_smp_x;
    end
  end

  // LAM two-flop synchroniser plus registered OR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lam_meta <= '0; r_lam <= '0; r_lam_any <= 1'b0;
    end else begin
      r_lam_meta <= cw_l;
      r_lam      <= r_lam_meta;
      r_lam_any  <= |r_lam;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_q     = r_rsp_q;
  assign rsp_x     = r_rsp_x;
  assign cw_n      = r_cw_n;
  assign cw_a      = r_cw_a;
  assign cw_f      = r_cw_f;
  assign cw_w      = r_cw_w;
  assign cw_b      = r_cw_b;
  assign cw_s1     = r_cw_s1;
  assign cw_s2     = r_cw_s2;
  assign cw_z      = r_cw_z;
  assign cw_c      = r_cw_c;
  assign lam       = r_lam;
  assign lam_any   = r_lam_any;

endmodule

// File: tb/tb_camac_dataway_initiator.sv
// Bench for camac_dataway_initiator: table of directed commands, randomized
// commands against a timeline model, mid-cycle reset and LAM sequences.
module tb_camac_dataway_initiator;

  localparam int TS = 10, T1 = 5, TG = 5, T2 = 5, TH = 5;
  localparam int BUSY_END = TS + T1 + TG + T2 + TH;
  localparam int S1_LO = TS + 1, S1_HI = TS + T1;
  localparam int S2_LO = TS + T1 + TG + 1, S2_HI = TS + T1 + TG + T2;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_n, cmd_f;
  logic [3:0]  cmd_a;
  logic [23:0] cmd_wdata;
  logic        cmd_z, cmd_c;
  logic        rsp_valid, rsp_ready;
  logic [23:0] rsp_rdata;
  logic        rsp_q, rsp_x;
  logic [23:0] cw_n, cw_w, cw_r, cw_l, lam;
  logic [3:0]  cw_a;
  logic [4:0]  cw_f;
  logic        cw_b, cw_s1, cw_s2, cw_z, cw_c, cw_q, cw_x, lam_any;

  int checks = 0;
  int errors = 0;

  camac_dataway_initiator #(
    .T_SETUP(TS), .T_S1(T1), .T_GAP(TG), .T_S2(T2), .T_HOLD(TH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n(cmd_n), .cmd_a(cmd_a), .cmd_f(cmd_f), .cmd_wdata(cmd_wdata),
    .cmd_z(cmd_z), .cmd_c(cmd_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_q(rsp_q), .rsp_x(rsp_x),
    .cw_n(cw_n), .cw_a(cw_a), .cw_f(cw_f), .cw_w(cw_w), .cw_b(cw_b),
    .cw_s1(cw_s1), .cw_s2(cw_s2), .cw_z(cw_z), .cw_c(cw_c),
    .cw_r(cw_r), .cw_q(cw_q), .cw_x(cw_x), .cw_l(cw_l),
    .lam(lam), .lam_any(lam_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [4:0]  n;
    logic [3:0]  a;
    logic [4:0]  f;
    logic [23:0] wd;
    logic        z, c;
    logic [23:0] r;
    logic        q, x;
    int          hold;
    logic [23:0] en;
    logic [23:0] erd;
    logic        eq, ex;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] n, input logic [3:0] a, input logic [4:0] f,
                              input logic [23:0] wd, input logic z, input logic c,
                              input logic [23:0] r, input logic q, input logic x, input int hold,
                              input logic [23:0] en, input logic [23:0] erd,
                              input logic eq, input logic ex);
    vec_t v;
    v.n = n; v.a = a; v.f = f; v.wd = wd; v.z = z; v.c = c;
    v.r = r; v.q = q; v.x = x; v.hold = hold;
    v.en = en; v.erd = erd; v.eq = eq; v.ex = ex;
    return v;
  endfunction

  function automatic logic [23:0] onehot(input logic [4:0] n);
    if (n >= 5'd1 && n <= 5'd23) return 24'd1 << (n - 5'd1);
    return 24'd0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] act_vec();
    return {cw_n, cw_a, cw_f, cw_w, cw_b, cw_s1, cw_s2, cw_z, cw_c, cmd_ready, rsp_valid};
  endfunction

  // Expected dataway/handshake picture j clocks after the accepting edge.
  function automatic logic [63:0] exp_vec(input vec_t v, input int j);
    logic busy, addr, wr, s1, s2, z, c;
    logic [23:0] n, w;
    logic [3:0] a;
    logic [4:0] f;
    busy = (j >= 1 && j <= BUSY_END);
    addr = !v.z && !v.c;
    wr   = (v.f >= 5'd16 && v.f <= 5'd23);
    n = '0; w = '0; a = '0; f = '0; s1 = 1'b0; s2 = 1'b0; z = 1'b0; c = 1'b0;
    if (busy) begin
      if (addr) begin
        n = v.en; a = v.a; f = v.f;
        if (wr) w = v.wd;
        s1 = (j >= S1_LO && j <= S1_HI);
      end
      s2 = (j >= S2_LO && j <= S2_HI);
      z  = v.z;
      c  = v.c && !v.z;
    end
    return {n, a, f, w, busy, s1, s2, z, c, 1'b0, (j > BUSY_END)};
  endfunction

  task automatic junk_cmd();
    cmd_n = 5'($urandom); cmd_a = 4'($urandom); cmd_f = 5'($urandom);
    cmd_wdata = 24'($urandom); cmd_z = 1'($urandom); cmd_c = 1'($urandom);
  endtask

  task automatic drive_cmd(input vec_t v);
    chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    cmd_n = v.n; cmd_a = v.a; cmd_f = v.f; cmd_wdata = v.wd; cmd_z = v.z; cmd_c = v.c;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    junk_cmd();
  endtask

  // Drive one cycle. Inputs change every clock; during S1 the table value (or
  // a random one) is driven and the last S1 value is what must come back.
  task automatic run(input vec_t v, input bit use_tab);
    logic [23:0] er, dr;
    logic        eq, ex, dq, dx, addr, rd;
    logic [63:0] ersp;
    int j;
    er = '0; eq = 1'b0; ex = 1'b0;
    drive_cmd(v);
    for (j = 0; j <= BUSY_END; j++) begin
      chk($sformatf("dataway_j%0d", j), act_vec(), exp_vec(v, j));
      dr = 24'($urandom); dq = 1'($urandom); dx = 1'($urandom);
      if (j >= S1_LO && j <= S1_HI) begin
        if (use_tab) begin dr = v.r; dq = v.q; dx = v.x; end
        er = dr; eq = dq; ex = dx;
      end
      cw_r = dr; cw_q = dq; cw_x = dx;
      @(negedge clk);
    end
    addr = !v.z && !v.c;
    rd   = (v.f <= 5'd7);
    if (use_tab) ersp = {39'd0, v.erd, v.eq, v.ex};
    else         ersp = {39'd0, (addr && rd) ? er : 24'd0, addr && eq, addr && ex};
    if (v.hold > 0) begin
      cmd_valid = 1'b1;
      junk_cmd();
    end
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_dataway", act_vec(), exp_vec(v, j));
      chk("hold_rsp_fields", {39'd0, rsp_rdata, rsp_q, rsp_x}, ersp);
      j++;
      @(negedge clk);
    end
    chk("rsp_fields", {39'd0, rsp_rdata, rsp_q, rsp_x}, ersp);
    chk("rsp_valid_up", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("after_handshake", {62'd0, cmd_ready, rsp_valid}, 64'b10);
  endtask

  vec_t tab[9];
  vec_t rv;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_n = '0; cmd_a = '0; cmd_f = '0; cmd_wdata = '0; cmd_z = 1'b0; cmd_c = 1'b0;
    cw_r = '0; cw_q = 1'b0; cw_x = 1'b0; cw_l = '0;

    tab[0] = mk(5'd5,  4'd0,  5'd0,  24'h000000, 0, 0, 24'hABCDEF, 1, 1, 0,  24'h000010, 24'hABCDEF, 1, 1);
    tab[1] = mk(5'd3,  4'd2,  5'd16, 24'h0000AA, 0, 0, 24'h123456, 0, 1, 0,  24'h000004, 24'h000000, 0, 1);
    tab[2] = mk(5'd7,  4'd1,  5'd9,  24'h5A5A5A, 0, 0, 24'hFFFFFF, 1, 0, 0,  24'h000040, 24'h000000, 1, 0);
    tab[3] = mk(5'd5,  4'd3,  5'd16, 24'hFFFFFF, 1, 1, 24'h111111, 1, 1, 10, 24'h000000, 24'h000000, 0, 0);
    tab[4] = mk(5'd0,  4'd0,  5'd2,  24'h000000, 0, 0, 24'h000055, 1, 0, 0,  24'h000000, 24'h000055, 1, 0);
    tab[5] = mk(5'd31, 4'd4,  5'd23, 24'h000123, 0, 0, 24'h000000, 1, 1, 0,  24'h000000, 24'h000000, 1, 1);
    tab[6] = mk(5'd23, 4'd15, 5'd7,  24'h000000, 0, 0, 24'h800001, 0, 1, 0,  24'h400000, 24'h800001, 0, 1);
    tab[7] = mk(5'd9,  4'd0,  5'd0,  24'h000000, 0, 1, 24'hAAAAAA, 1, 1, 0,  24'h000000, 24'h000000, 0, 0);
    tab[8] = mk(5'd2,  4'd6,  5'd24, 24'h777777, 0, 0, 24'h0F0F0F, 1, 1, 0,  24'h000002, 24'h000000, 1, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", act_vec(), 64'b10);
    chk("reset_rsp", {39'd0, rsp_rdata, rsp_q, rsp_x}, 64'd0);
    chk("reset_lam", {39'd0, lam, lam_any}, 64'd0);

    for (int i = 0; i < 9; i++) run(tab[i], 1'b1);

    // Reset during S1: dataway drops at the next edge, response discarded.
    drive_cmd(tab[0]);
    for (int j = 0; j < S1_LO + 2; j++) begin
      cw_q = 1'($urandom); cw_r = 24'($urandom);
      @(negedge clk);
    end
    chk("in_s1_before_reset", 64'(cw_s1), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midcycle_reset", act_vec(), 64'b10);
    repeat (BUSY_END + 2) @(negedge clk);
    chk("stays_idle_after_reset", act_vec(), 64'b10);
    run(mk(5'd1, 4'd0, 5'd0, 24'h0, 0, 0, 24'h13579B, 0, 1, 0, 24'h000001, 24'h13579B, 0, 1), 1'b1);

    // LAM synchroniser latency.
    cw_l = 24'h000010;
    @(negedge clk);
    chk("lam_1clk", {39'd0, lam, lam_any}, 64'd0);
    @(negedge clk);
    chk("lam_2clk", {39'd0, lam, lam_any}, {39'd0, 24'h000010, 1'b0});
    @(negedge clk);
    chk("lam_any_3clk", {39'd0, lam, lam_any}, {39'd0, 24'h000010, 1'b1});
    cw_l = 24'h000000;
    repeat (2) @(negedge clk);
    chk("lam_clear", {39'd0, lam, lam_any}, {39'd0, 24'h000000, 1'b1});
    @(negedge clk);
    chk("lam_any_clear", 64'(lam_any), 64'd0);

    // Randomized commands against the timeline model.
    for (int i = 0; i < 40; i++) begin
      rv.n = 5'($urandom); rv.a = 4'($urandom); rv.f = 5'($urandom);
      rv.wd = 24'($urandom);
      rv.z = ($urandom_range(0, 7) == 0); rv.c = ($urandom_range(0, 7) == 0);
      rv.r = '0; rv.q = 1'b0; rv.x = 1'b0;
      rv.hold = $urandom_range(0, 3);
      rv.en = onehot(rv.n);
      rv.erd = '0; rv.eq = 1'b0; rv.ex = 1'b0;
      run(rv, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camac_dataway_initiator.md
Name: camac_dataway_initiator

Overview:
- Crate-controller side of the CAMAC dataway: accepts one N·A·F command at a time from the host-side sequencer and drives the dataway cycle (N/A/F/W, B, S1, S2).
- Samples R, Q and X and returns a response.
- Also runs the unaddressed Z (initialise) and C (clear) cycles.
- Slots between the host command path and the physical dataway transceivers, driving station modules such as the Mössbauer accumulator.

Parameters:
- T_SETUP, 10, clocks that N/A/F/W/B are stable before S1.
- T_S1, 5, S1 strobe width in clocks.
- T_GAP, 5, clocks between S1 fall and S2 rise.
- T_S2, 5, S2 strobe width in clocks.
- T_HOLD, 5, clocks that N/A/F/W/B stay stable after S2 fall.

Ports:
- clk in 1 system clock
- rst in 1 reset
- cmd_valid in 1 command request
- cmd_ready out 1 command accepted when high together with cmd_valid
- cmd_n in 5 station number
- cmd_a in 4 subaddress
- cmd_f in 5 function code
- cmd_wdata in 24 write data
- cmd_z in 1 request Z cycle (ignores N/A/F)
- cmd_c in 1 request C cycle (ignores N/A/F)
- rsp_valid out 1 response available
- rsp_ready in 1 response consumed
- rsp_rdata out 24 read data
- rsp_q out 1 sampled Q
- rsp_x out 1 sampled X
- cw_n out 24 station lines, bit k-1 = station k (k=1..23); bit 23 always 0
- cw_a out 4 A lines
- cw_f out 5 F lines
- cw_w out 24 W lines
- cw_b out 1 busy
- cw_s1 out 1 strobe 1
- cw_s2 out 1 strobe 2
- cw_z out 1 initialise
- cw_c out 1 clear
- cw_r in 24 R lines
- cw_q in 1 Q response
- cw_x in 1 X response
- cw_l in 24 LAM lines
- lam out 24 synchronised LAM vector
- lam_any out 1 OR of lam

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. All outputs reset to 0 except cmd_ready, which resets to 1. State resets to IDLE.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, register the command and go to SETUP.
  - SETUP (T_SETUP clocks) -> S1 (T_S1) -> GAP (T_GAP) -> S2 (T_S2) -> HOLD (T_HOLD) -> RESP.
  - RESP: rsp_valid=1 until rsp_valid&rsp_ready, then IDLE.
  - cmd_ready=0 in every state except IDLE.
- Latency: the command is accepted at edge k. Dataway outputs change at edge k+1. cw_b=1 from k+1 for the whole SETUP..HOLD span, 25 clocks at defaults. rsp_valid rises at k+26.
- Addressed cycle:
  - cw_n is one-hot for cmd_n 1..23.
  - For cmd_n=0 or ≥24, cw_n=0; the cycle still runs and reports the sampled X (normally 0).
  - cw_a and cw_f are driven from the registered command.
  - cw_s1=1 in S1 only; cw_s2=1 in S2 only.
- Function classes:
  - Read: F[4:3]=00 (F0–F7).
  - Write: F[4:3]=10 (F16–F23). cw_w=wdata for the whole cycle, otherwise cw_w=0.
  - All other F are control.
- Sampling:
  - cw_q, cw_x and cw_r are registered on the last clock of S1.
  - rsp_rdata=sampled R for reads, else 0.
  - rsp_q and rsp_x are sampled for all addressed cycles.
  - Response fields hold stable while rsp_valid=1.
- Z/C cycle:
  - cw_n=0, cw_a=0, cw_f=0, cw_w=0.
  - cw_z or cw_c is held =1 for SETUP..HOLD; cw_b=1 throughout.
  - No S1 pulse (S1 phase duration kept, strobe low); S2 pulses normally.
  - Response: rdata=0, q=0, x=0.
  - cmd_z and cmd_c both set: Z cycle only.
  - cmd_z or cmd_c set: N/A/F/W are ignored.
- Command fields are captured only at acceptance. Input changes during a cycle have no effect.
- Reset mid-cycle: at the next edge all cw_* outputs go to 0 and the state goes to IDLE. The in-flight response is discarded; rsp_valid is 0.
- LAM path: cw_l passes through a two-flop synchroniser to lam. lam_any is the registered OR of lam. Latency is 2 clocks to lam and 3 to lam_any.
- Phase counters: use a single down-counter, sized for the maximum parameter value. Each phase with parameter value 0 is treated as 1 clock.

Test Plan:
- Read N=5,A=0,F=0, cw_r=0xABCDEF, q=1, x=1 -> cw_n=0x000010, S1 high clocks 11–15 after accept, S2 high clocks 21–25, rsp at +26: rdata=0xABCDEF, q=1, x=1; cw_w=0 throughout.
- Write N=3,A=2,F=16,wdata=0x0000AA, x=1, q=0 -> cw_w=0x0000AA for all 25 busy clocks; rsp rdata=0, q=0, x=1.
- Control F=9 (clear counters) to N=7 with S1-sampled Q=1 while cw_q toggles outside S1 -> rsp_q=1 regardless of cw_q outside the sampling clock; cw_w=0.
- Z with cmd_c also set -> cw_z=1 for 25 clocks, cw_c=0, no S1, one S2 pulse, cw_n=0; rsp all zero.
- Hold rsp_ready=0 for 10 clocks with cmd_valid high -> rsp fields stable, cmd_ready=0, no new cycle. After rsp_ready=1, cmd_ready=1 next clock and the next command is accepted.
- Assert rst during S1 -> next clock all cw_*=0, rsp_valid=0, cmd_ready=1. A subsequent N=1 read completes normally. Set cw_l bit 4 -> lam[4]=1 after 2 clocks, lam_any=1 after 3.
